// File: rtl/mmm_pkg.sv
// Shared types for the Montgomery modular-exponentiation sequencer:
// top-level steps, per-multiply phases and operand selects.
package mmm_pkg;

    localparam int MMM_MAX_W = 64;

    typedef enum logic [2:0] {
        S_IDLE  = 3'd0,
        S_PRE_X = 3'd1,
        S_PRE_A = 3'd2,
        S_SQR   = 3'd3,
        S_MUL   = 3'd4,
        S_POST  = 3'd5,
        S_DONE  = 3'd6
    } top_state_e;

    typedef enum logic [2:0] {
        PH_CLR  = 3'd0,
        PH_LOAD = 3'd1,
        PH_ITER = 3'd2,
        PH_CAPT = 3'd3,
        PH_WB   = 3'd4
    } phase_e;

    typedef enum logic [2:0] {
        SEL_ONE = 3'd0,
        SEL_MSG = 3'd1,
        SEL_R2  = 3'd2,
        SEL_A   = 3'd3,
        SEL_X   = 3'd4
    } opsel_e;

    // Constant one; callers cast it down to their operand width.
    function automatic logic [MMM_MAX_W-1:0] mmm_one();
        return {{(MMM_MAX_W-1){1'b0}}, 1'b1};
    endfunction

endpackage

// File: rtl/mmm_modexp_chk.sv
// Precondition checker: the modulus must be odd with 1 < N < 2^(WIDTH-1)
// whenever a start is accepted.
module mmm_modexp_chk #(
    parameter int WIDTH = 8
)(
    input logic             clk,
    input logic             rst,
    input logic             start,
    input logic             busy,
    input logic [WIDTH-1:0] modulus
);
    localparam logic [WIDTH-1:0] N_MIN = {{(WIDTH-1){1'b0}}, 1'b1};
    localparam logic [WIDTH-1:0] N_LIM = {1'b1, {(WIDTH-1){1'b0}}};

    a_modulus_ok: assert property (@(posedge clk) disable iff (rst)
        (start && !busy) |-> (modulus[0] && (modulus > N_MIN) && (modulus < N_LIM)));

endmodule

// File: rtl/mmm_op_seq.sv
// Phase counter for one Montgomery multiply: CLR, LOAD, WIDTH x ITER, CAPT, WB.
// Exposes the next phase so the caller can register its control outputs.
module mmm_op_seq
    import mmm_pkg::*;
#(
    parameter int WIDTH = 8
)(
    input  logic   clk,
    input  logic   rst,
    input  logic   go_i,
    output phase_e phase_nxt_o,
    output logic   active_nxt_o,
    output logic   op_done_o
);
    localparam int            CW       = $clog2(WIDTH + 4);
    localparam logic [CW-1:0] CNT_CAPT = CW'(WIDTH + 2);
    localparam logic [CW-1:0] CNT_WB   = CW'(WIDTH + 3);

    logic [CW-1:0] cnt_q, cnt_d;
    logic          active_q, active_d;

    // Next count: go restarts at CLR (chaining multiplies back to back), WB ends an idle-bound multiply.
    always_comb begin
        cnt_d    = cnt_q;
        active_d = active_q;
        if (go_i) begin
            cnt_d    = {CW{1'b0}};
            active_d = 1'b1;
        end else if (active_q && (cnt_q == CNT_WB)) begin
            cnt_d    = {CW{1'b0}};
            active_d = 1'b0;
        end else if (active_q) begin
            cnt_d = cnt_q + CW'(1);
        end else begin
            active_d = 1'b0;
        end
    end

    // Phase decode of the next count.
    always_comb begin
        phase_nxt_o = PH_ITER;
        if (cnt_d == {CW{1'b0}}) begin
            phase_nxt_o = PH_CLR;
        end else if (cnt_d == CW'(1)) begin
            phase_nxt_o = PH_LOAD;
        end else if (cnt_d == CNT_CAPT) begin
            phase_nxt_o = PH_CAPT;
        end else if (cnt_d == CNT_WB) begin
            phase_nxt_o = PH_WB;
        end else begin
            phase_nxt_o = PH_ITER;
        end
    end

    assign active_nxt_o = active_d;
    assign op_done_o    = active_q && (cnt_q == CNT_WB);

    // Counter state register.
    always_ff @(posedge clk) begin
        if (rst) begin
            cnt_q    <= {CW{1'b0}};
            active_q <= 1'b0;
        end else begin
            cnt_q    <= cnt_d;
            active_q <= active_d;
        end
    end

endmodule

// File: rtl/mmm_modexp_ctrl.sv
// Left-to-right Montgomery exponentiation sequencer driving one bit-serial
// multiplier; reduces each returned product below N before writing it back.
module mmm_modexp_ctrl
    import mmm_pkg::*;
#(
    parameter int WIDTH      = 8,
    parameter int CONST_TIME = 0
)(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] msg,
    input  logic [WIDTH-1:0] exp,
    input  logic [WIDTH-1:0] modulus,
    input  logic [WIDTH-1:0] r2_mod,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] result,
    output logic             mmm_ena,
    output logic             mmm_clear,
    output logic             mmm_ld_a,
    output logic             mmm_ld_r,
    output logic             mmm_lock,
    output logic [WIDTH-1:0] mmm_a,
    output logic [WIDTH-1:0] mmm_b,
    output logic [WIDTH-1:0] mmm_m,
    input  logic [WIDTH-1:0] mmm_r
);
    localparam int               IW  = $clog2(WIDTH);
    localparam logic [WIDTH-1:0] ONE = WIDTH'(mmm_one());

    top_state_e       state_q, state_d;
    logic [WIDTH-1:0] msg_q, msg_d, exp_q, exp_d, mod_q, mod_d, r2_q, r2_d;
    logic [WIDTH-1:0] x_q, x_d, a_q, a_d, result_q, result_d;
    logic [WIDTH-1:0] mmm_a_q, mmm_a_d, mmm_b_q, mmm_b_d;
    logic [IW-1:0]    idx_q, idx_d;
    logic             busy_q, busy_d, done_q, done_d;
    logic             ena_q, ena_d, clear_q, clear_d, lda_q, lda_d, ldr_q, ldr_d, lock_q, lock_d;
    logic             seq_go, seq_active_nxt, seq_op_done, ge_n, exp_bit;
    phase_e           seq_phase_nxt;
    opsel_e           sel_a, sel_b;
    logic [WIDTH-1:0] red;

    function automatic logic [WIDTH-1:0] operand(input opsel_e sel, input logic [WIDTH-1:0] m_v,
                                                 input logic [WIDTH-1:0] r2_v, input logic [WIDTH-1:0] a_v,
                                                 input logic [WIDTH-1:0] x_v);
        case (sel)
            SEL_MSG: return m_v;
            SEL_R2:  return r2_v;
            SEL_A:   return a_v;
            SEL_X:   return x_v;
            default: return ONE;
        endcase
    endfunction

    mmm_op_seq #(.WIDTH(WIDTH)) u_seq (
        .clk          (clk),
        .rst          (rst),
        .go_i         (seq_go),
        .phase_nxt_o  (seq_phase_nxt),
        .active_nxt_o (seq_active_nxt),
        .op_done_o    (seq_op_done)
    );

    mmm_modexp_chk #(.WIDTH(WIDTH)) u_chk (
        .clk     (clk),
        .rst     (rst),
        .start   (start),
        .busy    (busy_q),
        .modulus (modulus)
    );

    // Product is < 2N, so one compare in WIDTH+1 bits and a single subtract fully reduce it.
    assign ge_n    = ({1'b0, mmm_r} >= {1'b0, mod_q});
    assign red     = ge_n ? (mmm_r - mod_q) : mmm_r;
    assign exp_bit = exp_q[idx_q];

    // Step sequencing; each WB cycle writes the reduced product and launches the next multiply.
    always_comb begin
        state_d  = state_q;
        msg_d    = msg_q;
        exp_d    = exp_q;
        mod_d    = mod_q;
        r2_d     = r2_q;
        x_d      = x_q;
        a_d      = a_q;
        idx_d    = idx_q;
        result_d = result_q;
        busy_d   = busy_q;
        done_d   = 1'b0;
        seq_go   = 1'b0;
        sel_a    = SEL_ONE;
        sel_b    = SEL_ONE;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    {msg_d, exp_d, mod_d, r2_d} = {msg, exp, modulus, r2_mod};
                    {state_d, busy_d, seq_go, sel_a, sel_b} = {S_PRE_X, 1'b1, 1'b1, SEL_MSG, SEL_R2};
                end else begin
                    state_d = S_IDLE;
                end
            end
            S_PRE_X: begin
                if (seq_op_done) begin
                    x_d = red;
                    {state_d, seq_go, sel_a, sel_b} = {S_PRE_A, 1'b1, SEL_R2, SEL_ONE};
                end else begin
                    state_d = S_PRE_X;
                end
            end
            S_PRE_A: begin
                if (seq_op_done) begin
                    a_d   = red;
                    idx_d = IW'(WIDTH - 1);
                    {state_d, seq_go, sel_a, sel_b} = {S_SQR, 1'b1, SEL_A, SEL_A};
                end else begin
                    state_d = S_PRE_A;
                end
            end
            S_SQR, S_MUL: begin
                if (seq_op_done) begin
                    // A dummy multiply for a zero bit lands in scratch: the product is discarded.
                    if ((state_q == S_SQR) || exp_bit) begin
                        a_d = red;
                    end else begin
                        a_d = a_q;
                    end
                    seq_go = 1'b1;
                    if ((state_q == S_SQR) && (exp_bit || (CONST_TIME != 32'sd0))) begin
                        {state_d, sel_a, sel_b} = {S_MUL, SEL_A, SEL_X};
                    end else if (idx_q == {IW{1'b0}}) begin
                        {state_d, sel_a, sel_b} = {S_POST, SEL_A, SEL_ONE};
                    end else begin
                        idx_d = idx_q - IW'(1);
                        {state_d, sel_a, sel_b} = {S_SQR, SEL_A, SEL_A};
                    end
                end else begin
                    state_d = state_q;
                end
            end
            S_POST: begin
                if (seq_op_done) begin
                    result_d = red;
                    state_d  = S_DONE;
                end else begin
                    state_d = S_POST;
                end
            end
            S_DONE: begin
                {state_d, done_d, busy_d} = {S_IDLE, 1'b1, 1'b0};
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    // Operands are captured only when a multiply launches and then held for its whole duration.
    always_comb begin
        mmm_a_d = seq_go ? operand(sel_a, msg_d, r2_d, a_d, x_d) : mmm_a_q;
        mmm_b_d = seq_go ? operand(sel_b, msg_d, r2_d, a_d, x_d) : mmm_b_q;
        ena_d   = seq_active_nxt && (seq_phase_nxt != PH_WB);
        clear_d = seq_active_nxt && (seq_phase_nxt == PH_CLR);
        lda_d   = seq_active_nxt && (seq_phase_nxt == PH_LOAD);
        ldr_d   = seq_active_nxt && (seq_phase_nxt == PH_CAPT);
        lock_d  = (state_d == S_IDLE) || (seq_active_nxt && (seq_phase_nxt == PH_WB));
    end

    // State, datapath and output registers.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            {msg_q, exp_q, mod_q, r2_q, x_q, a_q, result_q} <= {(7*WIDTH){1'b0}};
            {mmm_a_q, mmm_b_q} <= {(2*WIDTH){1'b0}};
            idx_q <= {IW{1'b0}};
            {busy_q, done_q, ena_q, clear_q, lda_q, ldr_q, lock_q} <= 7'b0000000;
        end else begin
            state_q <= state_d;
            {msg_q, exp_q, mod_q, r2_q, x_q, a_q, result_q} <= {msg_d, exp_d, mod_d, r2_d, x_d, a_d, result_d};
            {mmm_a_q, mmm_b_q} <= {mmm_a_d, mmm_b_d};
            idx_q <= idx_d;
            {busy_q, done_q, ena_q, clear_q, lda_q, ldr_q, lock_q} <=
                {busy_d, done_d, ena_d, clear_d, lda_d, ldr_d, lock_d};
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign result    = result_q;
    assign mmm_ena   = ena_q;
    assign mmm_clear = clear_q;
    assign mmm_ld_a  = lda_q;
    assign mmm_ld_r  = ldr_q;
    assign mmm_lock  = lock_q;
    assign mmm_a     = mmm_a_q;
    assign mmm_b     = mmm_b_q;
    assign mmm_m     = mod_q;

endmodule

// File: doc/mmm_modexp_ctrl.md
Name: mmm_modexp_ctrl

Overview:
- Initiator-side sequencer for the bit-serial Montgomery multiplier datapath.
- Computes result = msg^exp mod modulus by issuing a sequence of Montgomery multiplications (MMMs) over the multiplier's control/operand interface.
- Performs the final conditional subtraction on each returned product.
- Sits between the RSA register file (start/done handshake) and one multiplier instance.

Parameters:
- WIDTH, 8, operand/exponent width; Montgomery radix R = 2^WIDTH.
- CONST_TIME, 0, 1 = perform a dummy multiply when an exponent bit is 0, making latency independent of exp.

Ports:
- clk  in  1  clock.
- rst  in  1  reset: synchronous, active-high.
- start  in  1  begin operation; sampled only in IDLE.
- msg  in  WIDTH  base, < modulus.
- exp  in  WIDTH  exponent, scanned MSB first.
- modulus  in  WIDTH  N; odd, 1 < N < 2^(WIDTH-1).
- r2_mod  in  WIDTH  R^2 mod N, precomputed by software.
- busy  out  1  high from the cycle after start is accepted until done.
- done  out  1  single-cycle pulse when result is valid.
- result  out  WIDTH  msg^exp mod N; held until next accepted start.
- mmm_ena  out  1  multiplier clock enable.
- mmm_clear  out  1  multiplier synchronous clear.
- mmm_ld_a  out  1  load serial operand A.
- mmm_ld_r  out  1  capture product into result register.
- mmm_lock  out  1  freeze multiplier result register.
- mmm_a  out  WIDTH  serial operand A.
- mmm_b  out  WIDTH  parallel operand B.
- mmm_m  out  WIDTH  modulus (latched copy).
- mmm_r  in  WIDTH  product A*B*R^-1 mod N, < 2N.

Behaviour:
- Reset (any cycle, including mid-operation):
  - FSM goes to IDLE.
  - busy, done, result, all mmm_* outputs and internal registers X, A and the bit index are zero.
  - Reset mid-operation abandons the operation; no done pulse is produced.
- start:
  - In IDLE, start=1 latches msg, exp, modulus and r2_mod; busy rises next cycle.
  - start while busy is ignored; latched inputs are unaffected.
- Per-MMM sub-sequence (counter-driven, WIDTH+4 cycles). mmm_a and mmm_b are held stable throughout.
  - CLR: mmm_clear=1, mmm_ena=1.
  - LOAD: mmm_ld_a=1, mmm_ena=1.
  - ITER: WIDTH cycles with mmm_ena=1.
  - CAPT: mmm_ld_r=1, mmm_ena=1.
  - WB: t = mmm_r; the destination register receives (t >= N) ? t-N : t. The compare/subtract is WIDTH+1 bits wide.
- mmm_lock:
  - 1 in IDLE and in the WB cycle.
  - 0 otherwise.
- Top FSM (each step is one MMM written as (A operand, B operand) -> destination):
  - IDLE -> PRE_X: (msg, r2_mod) -> X.
  - PRE_X -> PRE_A: (r2_mod, 1) -> A. A now holds R mod N.
  - PRE_A -> SQR: i = WIDTH-1. SQR: (A, A) -> A.
  - After SQR:
    - exp[i]=1: go to MUL, (A, X) -> A.
    - exp[i]=0 and CONST_TIME=1: go to MUL, (A, X) -> scratch; A is unchanged.
    - exp[i]=0 and CONST_TIME=0: skip MUL.
  - After a bit is finished: if i=0 go to POST, else decrement i and go to SQR.
  - POST: (A, 1) -> result.
  - POST -> DONE: done=1 for one cycle, busy=0. Then go to IDLE.
- Latency:
  - Operation count: ops = 3 + WIDTH + popcount(exp), or 3 + 2*WIDTH when CONST_TIME=1.
  - done is asserted exactly ops*(WIDTH+4)+1 cycles after the start-accept edge.
- Boundaries:
  - exp=0 -> result 1.
  - msg=0 with exp>0 -> result 0.
  - Even N or N >= 2^(WIDTH-1): precondition violation. A simulation assertion fires on start; the output is undefined.

Decomposition:
- Package mmm_pkg:
  - top-state enum (IDLE, PRE_X, PRE_A, SQR, MUL, POST, DONE);
  - sub-phase enum (CLR, LOAD, ITER, CAPT, WB);
  - operand-select enum for the A/B muxes;
  - constant ONE function, sized WIDTH.
- Sub-module mmm_op_seq: the per-MMM phase counter. Interface: go, phase outputs, op_done.

Test Plan:
- WIDTH=8, N=119, r2_mod=86, msg=10, exp=5 -> result=40; done exactly 13*12+1=157 cycles after start accept; mmm_clear pulses 13 times.
- Same N, msg=40, exp=77 -> result=10, verifying the round trip with the private exponent.
- exp=0, msg=55 -> result=1. Then msg=0, exp=9 -> result=0.
- CONST_TIME=1, exp=5 then exp=255 -> identical latency of 19*12+1=229 cycles; results 40 and 10^255 mod 119 (golden model).
- start re-pulsed while busy with different msg -> ignored, result unchanged. rst asserted at cycle 50 -> next cycle all outputs 0, state IDLE, no done; a fresh start then completes correctly.
- Random (odd N < 128, msg < N, exp) x1000 against a reference model; check busy/done framing and that mmm_ld_r occurs exactly WIDTH+1 cycles after each mmm_ld_a.
